// File: rtl/serial_less_equal_if.sv
// serial_less_equal_if
// Purpose: bundles the serial comparator's handshake and result signals.
//   master modport: the side streaming operand bits (drives start/bit pairs).
//   slave  modport: the comparator itself (drives ready/busy/done/results).
// Signals:
//   start     - begin a new comparison (honoured only while idle)
//   bit_valid - a_bit/b_bit carry a valid bit pair this cycle
//   a_bit     - operand A bit, LSB first
//   b_bit     - operand B bit, LSB first
//   ready     - comparator is accepting bit pairs
//   busy      - comparison in progress or result being presented
//   done      - one-cycle pulse, result valid this cycle
//   equal     - A == B, held until the next accepted start
//   less      - A <  B, held until the next accepted start
interface serial_less_equal_if;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic ready;
  logic busy;
  logic done;
  logic equal;
  logic less;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  ready, busy, done, equal, less
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output ready, busy, done, equal, less
  );
endinterface

// File: rtl/serial_less_equal.sv
// serial_less_equal
// Purpose: bit-serial magnitude comparator. Two WIDTH-bit operands arrive one
//   bit pair per accepted cycle, LSB first; equal/less are reported with a
//   one-cycle done pulse after the last pair.
// Parameters:
//   WIDTH - bit pairs per comparison (minimum 2)
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - serial_less_equal_if.slave (start, bit_valid, a_bit, b_bit in;
//           ready, busy, done, equal, less out)
// Configuration:
//   SERIAL_LESS_EQUAL_SIGNED_EN - when defined, operands are two's complement:
//   a differing sign bit pair decides "less" in favour of the negative operand.
module serial_less_equal #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_less_equal_if.slave    bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_eq;
  logic              r_lt;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_equal;
  logic              r_less;

  logic              w_diff;
  logic              w_last;
  logic              w_ltBit;
  logic              w_eqNext;
  logic              w_ltNext;

  assign w_diff = bus.a_bit ^ bus.b_bit;
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // On a differing pair the operand whose bit is 0 is the smaller one, so the
  // B bit is the "A < B" answer. For a differing sign bit the roles swap:
  // the operand with the 1 sign bit is negative and therefore smaller.
`ifdef SERIAL_LESS_EQUAL_SIGNED_EN
  assign w_ltBit = w_last ? bus.a_bit : bus.b_bit;
`else
  assign w_ltBit = bus.b_bit;
`endif

  // Bits arrive LSB first, so each new differing bit is more significant
  // than any earlier one and simply overwrites the working verdict.
  assign w_eqNext = w_diff ? 1'b0    : r_eq;
  assign w_ltNext = w_diff ? w_ltBit : r_lt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_equal <= 1'b0;
      r_less  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_eq    <= 1'b1;
            r_lt    <= 1'b0;
            r_equal <= 1'b0;
            r_less  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.bit_valid) begin
            r_eq <= w_eqNext;
            r_lt <= w_ltNext;
            if (w_last) begin
              // Counter is left as-is on the final pair so it never wraps.
              r_state <= DONE;
              r_equal <= w_eqNext;
              r_less  <= w_ltNext;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.equal = r_equal;
  assign bus.less  = r_less;

endmodule

// File: doc/serial_less_equal.md
# serial_less_equal

Bit-serial magnitude comparator that receives two WIDTH-bit operands one bit pair per cycle, LSB first, and reports `equal` and `less` once the last bit arrives. It complements the parallel four-bit less/equal comparator: same flags, but it takes its operands from serial links. In the ALU it lets operands streamed from shift registers be compared without first being deserialised.

## Interface
- `WIDTH`, default 4: number of bit pairs per comparison; minimum 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a new comparison; sampled only in IDLE.
- `bit_valid`  in  1  `a_bit`/`b_bit` carry a valid bit pair this cycle.
- `a_bit`  in  1  operand A bit, LSB first.
- `b_bit`  in  1  operand B bit, LSB first.
- `ready`  out  1  high in SHIFT; a bit pair is accepted when `ready && bit_valid`.
- `busy`  out  1  high in SHIFT and DONE.
- `done`  out  1  one-cycle pulse; result is valid in this cycle.
- `equal`  out  1  A == B; held from `done` until the next accepted `start`.
- `less`  out  1  A < B; held from `done` until the next accepted `start`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: `start=1` → SHIFT. The same edge clears the bit counter to 0, the working `eq_r` to 1 and the working `lt_r` to 0.
  - SHIFT: each accepted pair updates the working registers and increments the counter.
    - If `a_bit != b_bit`: `eq_r <= 0` and `lt_r <= b_bit`.
    - If the bits match: both working registers are kept.
    - A later, more significant differing bit overrides an earlier one.
  - When the accepted pair is number WIDTH (counter == WIDTH-1) → DONE. The same edge loads the output registers `equal` and `less` from the final working values.
  - DONE: `done=1` for exactly one cycle, then → IDLE unconditionally.
- Counter width is ceil(log2(WIDTH)) bits. It never wraps within a comparison because exit happens on the final increment.
- `bit_valid` outside SHIFT is ignored. `start` outside IDLE is ignored.
- Gaps (`bit_valid=0`) in SHIFT stall the FSM indefinitely with no timeout.
- `equal` and `less` keep the previous result through IDLE. They clear to 0 on the edge that accepts the next `start`.
- `equal` and `less` are never both 1.

## Timing
- Reset values: state IDLE, `ready=0`, `busy=0`, `done=0`, `equal=0`, `less=0`, counter 0.
- Cycle 0: `start` is sampled in IDLE. Cycle 1: `ready=1`.
- With back-to-back `bit_valid`, the bits are accepted in cycles 1..WIDTH, `done` is high in cycle WIDTH+1, and IDLE is entered in cycle WIDTH+2.
- Minimum latency from start to `done` is WIDTH+1 cycles.
- Minimum start-to-start spacing is WIDTH+2 cycles, because `start` asserted during DONE is ignored.
- Reset has priority over every event, including mid-SHIFT and during DONE. A partial comparison is discarded with no `done` pulse.
- `start` and `reset` asserted together: reset wins and the state stays IDLE.

## Configuration
- `SERIAL_LESS_EQUAL_SIGNED_EN` defined: operands are two's complement.
  - When the final (sign) bit pair differs, `lt_r <= a_bit` instead of `b_bit`.
  - All other bit positions behave as unsigned.
- Undefined: unsigned comparison throughout, as described under Operation.

## Test plan
- Reset, then A=0101, B=0101 streamed back-to-back (LSB first: 1/1, 0/0, 1/1, 0/0). Required: `done` in cycle 5, with `equal=1`, `less=0`.
- A=0011, B=1000 (unsigned). Required: `less=1`, `equal=0`. The low bits favour A, but the MSB decides.
- A=1001, B=0111 with `bit_valid` low for 3 cycles between bits 1 and 2. Required: `less=0`, `equal=0`, and `done` delayed by exactly 3 cycles.
- Reset asserted after 2 accepted bits. Required: the next cycle shows IDLE with all outputs 0 and no `done`. A following compare of A=0000, B=0001 gives `less=1`.
- `start` held high continuously with A=B=1111 repeated. Required: `done` once every WIDTH+2 cycles, and `start` is ignored in SHIFT and DONE.
- With `SERIAL_LESS_EQUAL_SIGNED_EN`, A=1000 (-8), B=0111 (+7). Required: `less=1`. The same stimulus without the macro gives `less=0`.
